// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF stage and the
// memory controller.
//
// Lookup is combinational on pc_in in the request cycle; hit data appears registered on
// inst_out with inst_valid_out one cycle later. A miss enters StRefill and holds
// if_req_out/inst_addr_out stable until inst_done_in returns the word, which is written
// to the line and forwarded to the IF stage.
//
// Optional feature: define ICACHE_STATS_EN to build the hit/miss counters. Without the
// macro both counter outputs are tied to zero.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall, freezes everything)
//   pc_req_in, pc_in, flush_in          : fetch side requests / redirect
//   inst_valid_out, inst_out            : fetch response (inst_out is zero when not valid)
//   if_req_out, inst_addr_out           : refill request to the memory controller
//   inst_done_in, inst_in               : refill completion and data
//   hit_cnt_out, miss_cnt_out           : statistics counters
module icache #(
  parameter int unsigned ICACHE_LINES = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        pc_req_in,
  input  logic [31:0] pc_in,
  input  logic        flush_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic        if_req_out,
  output logic [31:0] inst_addr_out,
  input  logic        inst_done_in,
  input  logic [31:0] inst_in,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out
);

  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e                  state_q, state_d;
  logic [ICACHE_LINES-1:0] valid_q, valid_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [31:0]             inst_q, inst_d;
  logic                    if_req_q, if_req_d;
  logic [31:0]             addr_q, addr_d;

  // Tag and data storage need no reset: valid bits alone qualify every entry.
  logic [TagW-1:0] tag_mem  [ICACHE_LINES];
  logic [31:0]     data_mem [ICACHE_LINES];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;
  logic            lookup_hit;
  logic            fill_we;
  logic            hit_evt, miss_evt;

  // Address bits [1:0] never participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_in[1:0];

  assign rd_idx = pc_in[IdxW+1:2];
  assign rd_tag = pc_in[31:IdxW+2];
  // The refill line comes from the address latched at the miss, not from the live pc_in.
  assign wr_idx = addr_q[IdxW+1:2];
  assign wr_tag = addr_q[31:IdxW+2];

  assign lookup_hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    inst_valid_d = 1'b0;
    inst_d       = '0;
    if_req_d     = if_req_q;
    addr_d       = addr_q;
    fill_we      = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;

    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (flush_in) begin
            // Redirect wins over a same-cycle request: nothing is looked up.
            if_req_d = 1'b0;
          end else if (pc_req_in) begin
            addr_d = {pc_in[31:2], 2'b00};
            if (lookup_hit) begin
              inst_valid_d = 1'b1;
              inst_d       = data_mem[rd_idx];
              hit_evt      = 1'b1;
            end else begin
              state_d  = StRefill;
              if_req_d = 1'b1;
              miss_evt = 1'b1;
            end
          end
        end
        StRefill: begin
          // pc_req_in/pc_in are ignored here so the controller sees a stable address.
          if (inst_done_in) begin
            fill_we         = 1'b1;
            valid_d[wr_idx] = 1'b1;
            if_req_d        = 1'b0;
            state_d         = StIdle;
            // A flush still keeps the fetched word in the cache, it just isn't delivered.
            if (!flush_in) begin
              inst_valid_d = 1'b1;
              inst_d       = inst_in;
            end
          end else if (flush_in) begin
            if_req_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      // Global stall: outputs hold their current value.
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      if_req_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      if_req_q     <= if_req_d;
      addr_q       <= addr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      data_mem[wr_idx] <= inst_in;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign inst_valid_out = inst_valid_q;
  assign inst_out       = inst_q;
  assign if_req_out     = if_req_q;
  assign inst_addr_out  = addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Events are already gated by rdy_in, so a stall freezes the counters too.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_evt) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;

  assign hit_cnt_out  = '0;
  assign miss_cnt_out = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected fetch responses into a queue and a
// negedge monitor pops/compares whenever inst_valid_out is seen. Refill-side outputs and
// counters are checked directly against hand-computed values.
module tb_icache;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        pc_req;
  logic [31:0] pc;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic        if_req;
  logic [31:0] inst_addr;
  logic        inst_done;
  logic [31:0] inst_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned hits_exp = 0;
  int unsigned misses_exp = 0;
  logic [31:0] exp_q[$];

  icache #(.ICACHE_LINES(128)) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .rdy_in        (rdy),
    .pc_req_in     (pc_req),
    .pc_in         (pc),
    .flush_in      (flush),
    .inst_valid_out(inst_valid),
    .inst_out      (inst),
    .if_req_out    (if_req),
    .inst_addr_out (inst_addr),
    .inst_done_in  (inst_done),
    .inst_in       (inst_data),
    .hit_cnt_out   (hit_cnt),
    .miss_cnt_out  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (inst_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got inst 0x%08h expected no response at %0t",
                 inst, $time);
      end else begin
        check("inst_out", inst, exp_q.pop_front());
      end
    end else begin
      check("inst_out_idle_zero", inst, 32'h0);
    end
  end

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_cnt", hit_cnt, hits_exp);
    check("miss_cnt", miss_cnt, misses_exp);
`else
    check("hit_cnt_tied", hit_cnt, 32'h0);
    check("miss_cnt_tied", miss_cnt, 32'h0);
`endif
  endtask

  // One-cycle request; on return outputs reflect the lookup result.
  task automatic lookup(input logic [31:0] a, input bit hit, input logic [31:0] d);
    @(negedge clk);
    pc_req = 1'b1;
    pc     = a;
    if (hit) begin
      exp_q.push_back(d);
      hits_exp++;
    end else begin
      misses_exp++;
    end
    @(negedge clk);
    pc_req = 1'b0;
    check("if_req_after_lookup", {31'h0, if_req}, {31'h0, !hit});
    if (!hit) check("inst_addr_on_miss", inst_addr, a);
  endtask

  // Called while in refill: completes it with data d, optionally flushing the same cycle.
  task automatic refill(input logic [31:0] a, input logic [31:0] d, input bit fl);
    check("if_req_in_refill", {31'h0, if_req}, 32'h1);
    check("inst_addr_in_refill", inst_addr, a);
    inst_done = 1'b1;
    inst_data = d;
    flush     = fl;
    if (!fl) exp_q.push_back(d);
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = 32'h0;
    flush     = 1'b0;
    check("if_req_after_done", {31'h0, if_req}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] burst_a [4];
    logic [31:0] burst_d [4];
    burst_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    burst_d = '{32'h00000013, 32'h11111111, 32'h22222222, 32'h33333333};

    rst_n = 1'b0; rdy = 1'b1; pc_req = 1'b0; pc = '0; flush = 1'b0;
    inst_done = 1'b0; inst_data = '0;
    repeat (2) @(negedge clk);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_if_req", {31'h0, if_req}, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check_stats();
    rst_n = 1'b1;

    // Cold miss then hit on 0x0.
    lookup(32'h0, 1'b0, 32'h0);
    refill(32'h0, 32'h00000013, 1'b0);
    lookup(32'h0, 1'b1, 32'h00000013);
    check_stats();

    // Conflict on index 0 evicts 0x0.
    lookup(32'h200, 1'b0, 32'h0);
    refill(32'h200, 32'hDEADBEEF, 1'b0);
    lookup(32'h0, 1'b0, 32'h0);
    refill(32'h0, 32'h00000013, 1'b0);

    // pc changes during refill are ignored.
    lookup(32'h4, 1'b0, 32'h0);
    @(negedge clk);
    pc_req = 1'b1;
    pc     = 32'h8;
    @(negedge clk);
    check("addr_stable_in_refill", inst_addr, 32'h4);
    pc_req = 1'b0;
    refill(32'h4, 32'h11111111, 1'b0);
    lookup(32'h8, 1'b0, 32'h0);
    refill(32'h8, 32'h22222222, 1'b0);

    // Flush coincident with done: line written, nothing delivered.
    lookup(32'hC, 1'b0, 32'h0);
    refill(32'hC, 32'h33333333, 1'b1);
    lookup(32'hC, 1'b1, 32'h33333333);

    // Back-to-back hits, one per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc_req = 1'b1;
      pc     = burst_a[i];
      exp_q.push_back(burst_d[i]);
      hits_exp++;
    end
    @(negedge clk);
    pc_req = 1'b0;
    check("if_req_after_burst", {31'h0, if_req}, 32'h0);
    check_stats();

    // Flush beats a same-cycle request in idle.
    @(negedge clk);
    flush  = 1'b1;
    pc_req = 1'b1;
    pc     = 32'h30;
    @(negedge clk);
    flush  = 1'b0;
    pc_req = 1'b0;
    check("flush_blocks_req", {31'h0, if_req}, 32'h0);

    // Flush abandons a refill; a late done pulse is ignored.
    lookup(32'h34, 1'b0, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_drops_if_req", {31'h0, if_req}, 32'h0);
    inst_done = 1'b1;
    inst_data = 32'hBAD0BAD0;
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = 32'h0;
    lookup(32'h34, 1'b0, 32'h0);
    refill(32'h34, 32'h55555555, 1'b0);

    // rdy low freezes the refill; done during the stall is ignored.
    lookup(32'h20, 1'b0, 32'h0);
    @(negedge clk);
    rdy       = 1'b0;
    inst_done = 1'b1;
    inst_data = 32'h66666666;
    @(negedge clk);
    rdy       = 1'b1;
    inst_done = 1'b0;
    inst_data = 32'h0;
    check("stall_holds_if_req", {31'h0, if_req}, 32'h1);
    refill(32'h20, 32'h77777777, 1'b0);
    check_stats();

    // Reset mid-refill abandons it and invalidates the array.
    lookup(32'h10, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    hits_exp   = 0;
    misses_exp = 0;
    #1;
    check("async_rst_if_req", {31'h0, if_req}, 32'h0);
    check("async_rst_addr", inst_addr, 32'h0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inst_done = 1'b1;
    inst_data = 32'h88888888;
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = 32'h0;
    lookup(32'h4, 1'b0, 32'h0);
    refill(32'h4, 32'h44444444, 1'b0);

    // A request during a stall is not looked up.
    @(negedge clk);
    rdy    = 1'b0;
    pc_req = 1'b1;
    pc     = 32'h4;
    @(negedge clk);
    rdy    = 1'b1;
    pc_req = 1'b0;
    check("stall_no_req", {31'h0, if_req}, 32'h0);
    lookup(32'h4, 1'b1, 32'h44444444);
    check_stats();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
